// File: rtl/mem_align_pkg.sv
// Shared line-alignment definitions: line geometry, sequencing states and the
// lines-touched computation used by both the coalescer and the read merger.
package mem_align_pkg;

  localparam int LINE_BYTES = 128;
  localparam int LOG_LINE   = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_MID   = 2'd2
  } state_e;

  // Number of aligned lines spanned by [off, off+size); wide enough never to wrap.
  function automatic logic [32:0] calc_units(input logic [31:0] off,
                                             input logic [31:0] size,
                                             input int          log_line);
    logic [63:0] sum;
    sum = 64'(off) + 64'(size) + ((64'd1 << log_line) - 64'd1);
    return 33'(sum >> log_line);
  endfunction

endpackage

// File: rtl/byte_funnel_shift.sv
// Byte funnel shifter: selects LINE_BYTES bytes from {hi,lo} starting at byte
// off_i and zeroes every output byte at index >= nbytes_i.
module byte_funnel_shift #(
  parameter int LINE_BYTES = 128
) (
  input  logic [LINE_BYTES*8-1:0]      hi_i,
  input  logic [LINE_BYTES*8-1:0]      lo_i,
  input  logic [$clog2(LINE_BYTES)-1:0] off_i,
  input  logic [$clog2(LINE_BYTES):0]   nbytes_i,
  output logic [LINE_BYTES*8-1:0]      data_o
);

  localparam int LBW = LINE_BYTES * 8;
  localparam int LOG = $clog2(LINE_BYTES);

  logic [2*LBW-1:0] cat;
  logic [LBW-1:0]   shifted;

  assign cat     = {hi_i, lo_i};
  assign shifted = LBW'(cat >> {off_i, 3'b000});

  for (genvar i = 0; i < LINE_BYTES; i++) begin : g_mask
    assign data_o[8*i +: 8] = ((LOG+1)'(i) < nbytes_i) ? shifted[8*i +: 8] : 8'h00;
  end

endmodule

// File: rtl/line_realign_merger.sv
// Realigns in-order line responses of an unaligned read into beats starting at
// the requested byte. Optional oversize-request drop: ALIGN_MERGE_SIZE_CHECK_EN.
//
// state    | meaning
// ST_IDLE  | ready for a request; last beat may still be waiting in out reg
// ST_FIRST | waiting for the first line of the request (no beat possible yet)
// ST_MID   | building beats from prev line plus the next line (or prev alone)
module line_realign_merger
  import mem_align_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BYTES = mem_align_pkg::LINE_BYTES,
  parameter int MAX_UNITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [31:0]                   req_size,
  input  logic                          line_valid,
  output logic                          line_ready,
  input  logic [LINE_BYTES*8-1:0]       line_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LINE_BYTES*8-1:0]       out_data,
  output logic [$clog2(LINE_BYTES):0]   out_bytes,
  output logic                          out_last,
  output logic                          busy,
  output logic                          err
);

  localparam int LOG = $clog2(LINE_BYTES);
  localparam int LBW = LINE_BYTES * 8;

  state_e           state_q, state_d;
  logic [LOG-1:0]   off_q, off_d;
  logic [31:0]      rem_q, rem_d;
  logic [LBW-1:0]   prev_q, prev_d;
  logic             out_valid_q, out_valid_d;
  logic [LBW-1:0]   out_data_q, out_data_d;
  logic [LOG:0]     out_bytes_q, out_bytes_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  logic             out_free;
  logic             need_line;
  logic [LOG:0]     beat_bytes;
  logic             beat_last;
  logic [LBW-1:0]   beat_data;
  logic [32:0]      units;
  logic             oversize;
  logic             drop;
  logic             unused_bits;

  assign out_free   = !out_valid_q || out_ready;
  assign need_line  = ({1'b0, rem_q} + 33'(off_q)) > 33'(LINE_BYTES);
  assign beat_bytes = (rem_q >= 32'(LINE_BYTES)) ? (LOG+1)'(LINE_BYTES) : rem_q[LOG:0];
  assign beat_last  = rem_q <= 32'(LINE_BYTES);
  assign units      = calc_units(32'(req_addr[LOG-1:0]), req_size, LOG);
  assign oversize   = units > 33'(MAX_UNITS);

`ifdef ALIGN_MERGE_SIZE_CHECK_EN
  assign drop = oversize;
`else
  assign drop = 1'b0;
`endif

  assign unused_bits = ^{req_addr[ADDR_WIDTH-1:LOG], oversize};

  // In the tail case no line is taken, so the hi half only ever lands in masked bytes.
  byte_funnel_shift #(.LINE_BYTES(LINE_BYTES)) u_funnel (
    .hi_i     (line_data),
    .lo_i     (prev_q),
    .off_i    (off_q),
    .nbytes_i (beat_bytes),
    .data_o   (beat_data)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    rem_d       = rem_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    req_ready   = 1'b0;
    line_ready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = rst_n;
        if (req_valid && req_size != 32'd0) begin
          if (drop) begin
            err_d = 1'b1;
          end else begin
            off_d   = req_addr[LOG-1:0];
            rem_d   = req_size;
            state_d = ST_FIRST;
          end
        end
      end
      ST_FIRST: begin
        line_ready = 1'b1;
        if (line_valid) begin
          prev_d  = line_data;
          state_d = ST_MID;
        end
      end
      ST_MID: begin
        if (out_free) begin
          if (need_line) begin
            line_ready = 1'b1;
            if (line_valid) begin
              out_valid_d = 1'b1;
              out_data_d  = beat_data;
              out_bytes_d = beat_bytes;
              out_last_d  = beat_last;
              prev_d      = line_data;
              rem_d       = rem_q - 32'(beat_bytes);
              if (beat_last) state_d = ST_IDLE;
            end
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_bytes_d = beat_bytes;
            out_last_d  = 1'b1;
            rem_d       = 32'd0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      rem_q       <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      rem_q       <= rem_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_last  = out_last_q;
  assign busy      = state_q != ST_IDLE;
  assign err       = err_q;

endmodule

// File: tb/tb_line_realign_merger.sv
// Bench for line_realign_merger: table-driven requests, randomized requests,
// and hand sequences for zero size, oversize and mid-request reset.
module tb_line_realign_merger;

  localparam int LB     = 128;
  localparam int LBW    = LB * 8;
  localparam int BUDGET = 600;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [63:0]      req_addr = '0;
  logic [31:0]      req_size = '0;
  logic             line_valid = 1'b0;
  logic             line_ready;
  logic [LBW-1:0]   line_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LBW-1:0]   out_data;
  logic [7:0]       out_bytes;
  logic             out_last;
  logic             busy;
  logic             err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  line_realign_merger #(.ADDR_WIDTH(64), .LINE_BYTES(LB), .MAX_UNITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last), .busy(busy), .err(err)
  );

  // Memory image: every byte address holds a value derived from the address.
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    logic [63:0] h;
    h = a * 64'd37 + (a >> 7) * 64'd11 + 64'd5;
    return h[7:0];
  endfunction

  function automatic logic [LBW-1:0] line_of(input logic [63:0] base);
    logic [LBW-1:0] v;
    v = '0;
    for (int i = 0; i < LB; i++) v[8*i +: 8] = mem_byte(base + 64'(i));
    return v;
  endfunction

  // Beat j of a request holds requested bytes j*LB.. in order, zero-padded.
  function automatic logic [LBW-1:0] exp_beat(input logic [63:0] addr, input int size, input int j);
    logic [LBW-1:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < LB; i++) begin
      idx = j * LB + i;
      if (idx < size) v[8*i +: 8] = mem_byte(addr + 64'(idx));
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [LBW-1:0] act, input logic [LBW-1:0] exp);
    int bad;
    nvec++;
    if (act !== exp) begin
      nerr++;
      bad = 0;
      for (int i = LB - 1; i >= 0; i--) if (act[8*i +: 8] !== exp[8*i +: 8]) bad = i;
      $display("FAIL %s: byte %0d got %0h want %0h", nm, bad, act[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  task automatic send_req(input logic [63:0] addr, input logic [31:0] size);
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    line_valid = 1'b0;
    out_ready  = 1'b0;
    #1 chk("req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic run_req(input logic [63:0] addr, input int size, input int exp_lines,
                         input int exp_beats, input int lv_pct, input int or_pct);
    logic [63:0] base;
    int k, nb, cyc, nexp;
    bit done;
    base = {addr[63:7], 7'b0};
    send_req(addr, 32'(size));
    k = 0; nb = 0; cyc = 0; done = 0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      req_valid  = 1'b0;
      line_valid = ($urandom_range(99) < 32'(lv_pct));
      line_data  = line_of(base + 64'(k) * 64'd128);
      out_ready  = ($urandom_range(99) < 32'(or_pct));
      #1;
      if (out_valid && !out_ready) chk("stall_line_ready", 64'(line_ready), 64'd0);
      if (line_valid && line_ready) k++;
      if (out_valid && out_ready) begin
        if (nb >= exp_beats) begin
          chk("extra_beat", 64'(nb), 64'(exp_beats - 1));
          done = 1;
        end else begin
          nexp = (size - nb * LB > LB) ? LB : size - nb * LB;
          chk("out_bytes", 64'(out_bytes), 64'(nexp));
          chk("out_last", 64'(out_last), 64'(nb == exp_beats - 1));
          chk_data("out_data", out_data, exp_beat(addr, size, nb));
          if (out_last) done = 1;
          nb++;
        end
      end
      cyc++;
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL timeout: got %0d beats want %0d", nb, exp_beats);
    end
    @(negedge clk);
    line_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    chk("lines_consumed", 64'(k), 64'(exp_lines));
    chk("beats_emitted", 64'(nb), 64'(exp_beats));
    chk("idle_after", 64'({out_valid, busy, err}), 64'd0);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          size;
    int          lines;
    int          beats;
    int          lv;
    int          orp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [63:0] a;
    int s, off, k, cyc;

    tbl[0] = '{64'h1000, 256, 2, 2, 100, 100};
    tbl[1] = '{64'h1040, 128, 2, 1, 100, 100};
    tbl[2] = '{64'h1064,  50, 2, 1, 100, 100};
    tbl[3] = '{64'h1040, 200, 3, 2, 100,  50};
    tbl[4] = '{64'h1000, 128, 1, 1,  70,  70};
    tbl[5] = '{64'h107F,   1, 1, 1, 100, 100};
    tbl[6] = '{64'h107F,   2, 2, 1,  60,  40};
    tbl[7] = '{64'h2010, 500, 5, 4,  50,  50};

    // Reset values while held in reset.
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_outs", 64'({line_ready, out_valid, out_last, busy, err}), 64'd0);
    chk("rst_out_bytes", 64'(out_bytes), 64'd0);
    chk_data("rst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      run_req(tbl[i].addr, tbl[i].size, tbl[i].lines, tbl[i].beats, tbl[i].lv, tbl[i].orp);

    // Zero-size request: nothing consumed, nothing emitted.
    send_req(64'h1234, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      line_valid = 1'b1;
      out_ready  = 1'b1;
      #1 chk("size0_quiet", 64'({req_ready, line_ready, out_valid, busy}), 64'b1000);
    end
    line_valid = 1'b0;

    // Oversize request (9 lines).
`ifdef ALIGN_MERGE_SIZE_CHECK_EN
    send_req(64'h2000, 32'd1100);
    @(negedge clk);
    req_valid  = 1'b0;
    line_valid = 1'b1;
    #1 chk("oversize_err", 64'({err, busy, line_ready}), 64'b100);
    @(negedge clk);
    #1 chk("oversize_err_pulse", 64'({err, busy, line_ready}), 64'b000);
    line_valid = 1'b0;
`else
    run_req(64'h2000, 1100, 9, 9, 80, 80);
`endif

    // Reset while the first beat of a 3-beat request waits.
    send_req(64'h3000, 32'd384);
    k = 0; cyc = 0;
    do begin
      @(negedge clk);
      req_valid  = 1'b0;
      line_valid = 1'b1;
      line_data  = line_of(64'h3000 + 64'(k) * 64'd128);
      #1;
      if (line_ready) k++;
      cyc++;
    end while (!out_valid && cyc < 20);
    chk("mid_first_beat_seen", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({req_ready, line_ready, out_valid, out_last, busy, err}), 64'd0);
    chk("mid_rst_out_bytes", 64'(out_bytes), 64'd0);
    chk_data("mid_rst_out_data", out_data, '0);
    line_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_req(64'h1040, 200, 3, 2, 100, 50);

    // Randomized requests against the byte-level model.
    for (int r = 0; r < 30; r++) begin
      a   = {$urandom, $urandom};
      s   = int'($urandom_range(1, 600));
      off = int'(a[6:0]);
      run_req(a, s, (off + s + LB - 1) / LB, (s + LB - 1) / LB,
              int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
